sideband_rx_deframer: RTL

//  Receive side of the USB4 sideband channel: samples sbrx at bit rate, deserialises UART-style

---
 rtl/sideband_rx_deframer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sideband_rx_deframer.sv
`timescale 1ns/1ps
// Sideband receiver: sbrx bit stream -> UART characters -> de-framed, de-stuffed, CRC-checked payload.
// Latency: data byte k strobes 1 cycle after char_done of byte k+2; rx_done 1 cycle after ETX/offending char.
// Backpressure: none; the serial line cannot be stalled, so the consumer must accept every rx_valid strobe.
//
// Ports:
//   sb_clk    bit-rate clock, one cycle per serial bit
//   rst       asynchronous active-low reset
//   sb_en     receiver enable; low forces both FSMs idle and drops any partial transaction
//   sbrx      serial input, idle high
//   rx_data / rx_valid               de-stuffed payload byte and its one-cycle strobe
//   rx_done                          one-cycle end-of-transaction strobe
//   rx_is_rsp / rx_len / rx_err      transaction status, updated with rx_done and held until the next one
module sideband_rx_deframer #(
    parameter int         MAX_PAYLOAD = 64,
    parameter logic [7:0] DLE         = 8'hFE,
    parameter logic [7:0] STX_CMD     = 8'h05,
    parameter logic [7:0] STX_RSP     = 8'h04,
    parameter logic [7:0] ETX         = 8'h40,
    localparam int        LW          = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic          sb_clk,
    input  logic          rst,
    input  logic          sb_en,
    input  logic          sbrx,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    output logic          rx_done,
    output logic          rx_is_rsp,
    output logic [LW-1:0] rx_len,
    output logic [2:0]    rx_err
);

    localparam logic [2:0] ERR_OK     = 3'd0;
    localparam logic [2:0] ERR_FRAME  = 3'd1;
    localparam logic [2:0] ERR_ESCAPE = 3'd2;
    localparam logic [2:0] ERR_OVF    = 3'd3;
    localparam logic [2:0] ERR_SHORT  = 3'd4;
    localparam logic [2:0] ERR_CRC    = 3'd5;

    // CRC-16, poly 0x8005, MSB first, no reflection.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Input synchroniser (idle-high reset so no false start bit)
    // ------------------------------------------------------------------
    logic s1, s;

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b1;
            s  <= 1'b1;
        end else begin
            s1 <= sbrx;
            s  <= s1;
        end
    end

    // ------------------------------------------------------------------
    // Bit FSM: start bit, 8 data bits LSB first, stop bit
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {B_IDLE, B_DATA, B_STOP} bit_st_t;
    bit_st_t    bit_st, bit_nx;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       bit_shift, bit_stop;
    logic       char_done, cd_stop_ok;
    logic [7:0] cd_byte;

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) bit_st <= B_IDLE;
        else      bit_st <= bit_nx;
    end

    always_comb begin
        bit_nx = bit_st;
        case (bit_st)
            B_IDLE:  if (!s) bit_nx = B_DATA;
            B_DATA:  if (bit_cnt == 3'd7) bit_nx = B_STOP;
            B_STOP:  bit_nx = B_IDLE;
            default: bit_nx = B_IDLE;
        endcase
        if (!sb_en) bit_nx = B_IDLE;
    end

    always_comb begin
        bit_shift = sb_en && (bit_st == B_DATA);
        bit_stop  = sb_en && (bit_st == B_STOP);
    end

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            bit_cnt    <= 3'd0;
            shreg      <= 8'd0;
            char_done  <= 1'b0;
            cd_byte    <= 8'd0;
            cd_stop_ok <= 1'b0;
        end else begin
            if (bit_st == B_IDLE) bit_cnt <= 3'd0;
            else if (bit_shift)   bit_cnt <= bit_cnt + 3'd1;
            if (bit_shift) shreg <= {s, shreg[7:1]};
            char_done <= bit_stop;
            if (bit_stop) begin
                cd_byte    <= shreg;
                cd_stop_ok <= s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Character FSM: framing, de-stuffing, holding delay, CRC
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {C_WAIT_DLE, C_WAIT_STX, C_PAYLOAD, C_ESC} chr_st_t;
    chr_st_t       c_st, c_nx;
    logic [7:0]    h0, h1;        // h1 newest; the last two bytes are the CRC and are never emitted
    logic [1:0]    hcnt;
    logic [LW-1:0] len;
    logic [15:0]   crc;
    logic          is_rsp_q;
    logic          act_open, act_push, act_done;
    logic [7:0]    push_byte;
    logic [2:0]    done_err;

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) c_st <= C_WAIT_DLE;
        else      c_st <= c_nx;
    end

    always_comb begin
        c_nx = c_st;
        if (char_done) begin
            case (c_st)
                C_WAIT_DLE: if (cd_stop_ok && cd_byte == DLE) c_nx = C_WAIT_STX;
                C_WAIT_STX: begin
                    if (act_open)                               c_nx = C_PAYLOAD;
                    else if (!(cd_stop_ok && cd_byte == DLE))   c_nx = C_WAIT_DLE;
                end
                C_PAYLOAD:  if (cd_stop_ok && cd_byte == DLE) c_nx = C_ESC;
                C_ESC:      c_nx = C_PAYLOAD;   // only the DLE,DLE case survives act_done below
                default:    c_nx = C_WAIT_DLE;
            endcase
        end
        if (act_done) c_nx = C_WAIT_DLE;
        if (!sb_en)   c_nx = C_WAIT_DLE;
    end

    always_comb begin
        act_open  = 1'b0;
        act_push  = 1'b0;
        act_done  = 1'b0;
        push_byte = cd_byte;
        done_err  = ERR_OK;
        if (sb_en && char_done) begin
            case (c_st)
                C_WAIT_STX: act_open = cd_stop_ok && (cd_byte == STX_CMD || cd_byte == STX_RSP);
                C_PAYLOAD: begin
                    if (!cd_stop_ok) begin
                        act_done = 1'b1;
                        done_err = ERR_FRAME;
                    end else if (cd_byte != DLE) begin
                        act_push = 1'b1;
                    end
                end
                C_ESC: begin
                    if (!cd_stop_ok) begin
                        act_done = 1'b1;
                        done_err = ERR_FRAME;
                    end else if (cd_byte == DLE) begin
                        act_push  = 1'b1;
                        push_byte = DLE;
                    end else if (cd_byte == ETX) begin
                        act_done = 1'b1;
                        // len==0 means fewer than three de-stuffed bytes arrived
                        if (len == '0)          done_err = ERR_SHORT;
                        else if (crc != 16'h0)  done_err = ERR_CRC;
                        else                    done_err = ERR_OK;
                    end else begin
                        act_done = 1'b1;
                        done_err = ERR_ESCAPE;
                    end
                end
                default: ;
            endcase
            // A push that would emit beyond the payload limit ends the transaction instead
            if (act_push && hcnt == 2'd2 && len == LW'(MAX_PAYLOAD)) begin
                act_push = 1'b0;
                act_done = 1'b1;
                done_err = ERR_OVF;
            end
        end
    end

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            h0        <= 8'd0;
            h1        <= 8'd0;
            hcnt      <= 2'd0;
            len       <= '0;
            crc       <= 16'hFFFF;
            is_rsp_q  <= 1'b0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            rx_done   <= 1'b0;
            rx_is_rsp <= 1'b0;
            rx_len    <= '0;
            rx_err    <= ERR_OK;
        end else begin
            rx_valid <= 1'b0;
            rx_done  <= 1'b0;
            if (!sb_en) hcnt <= 2'd0;
            if (act_open) begin
                is_rsp_q <= (cd_byte == STX_RSP);
                len      <= '0;
                crc      <= 16'hFFFF;
                hcnt     <= 2'd0;
            end
            if (act_push) begin
                h0  <= h1;
                h1  <= push_byte;
                crc <= crc16_byte(crc, push_byte);
                if (hcnt == 2'd2) begin
                    rx_data  <= h0;
                    rx_valid <= 1'b1;
                    len      <= len + LW'(1);
                end else begin
                    hcnt <= hcnt + 2'd1;
                end
            end
            if (act_done) begin
                rx_done   <= 1'b1;
                rx_err    <= done_err;
                rx_len    <= len;
                rx_is_rsp <= is_rsp_q;
            end
        end
    end

endmodule
